ntt_stage_sequencer: RTL
========================

// Module: ntt_stage_sequencer
//
// PURPOSE
//   Top-level sequencer for the NTT datapath. It steps through all NUM_STAGES
//   butterfly stages. For each stage it runs the per-stage cycle counter over
//   STAGE_CYCLES read beats, then waits PIPE_LAT cycles for the butterfly
//   pipeline to drain before the next stage begins.
//   Outputs to the datapath: read/write enables, beat addresses, stage index
//   and the ping-pong bank select. Host interface: start/busy/done.
//
// PARAMETERS
//   NUM_STAGES   11   butterfly stages per transform (log2 N, N=2048)
//   STAGE_CYCLES 256  read beats per stage; power of 2, >= 2
//   PIPE_LAT     8    butterfly pipeline latency in cycles, rd -> wr; >= 1
//   CNT_W        8    log2(STAGE_CYCLES)
//   STG_W        4    ceil(log2(NUM_STAGES))
//
// PORTS
//   clk          in   1      clock
//   rst          in   1      reset, synchronous, active-high
//   start        in   1      1-cycle request to begin a transform
//   abort        in   1      synchronous abort, returns block to IDLE
//   busy         out  1      high in every state except IDLE
//   done         out  1      1-cycle pulse after the last write of the last stage
//   stage_idx    out  STG_W  current stage, 0..NUM_STAGES-1
//   rd_en        out  1      datapath read strobe, high in RUN only
//   rd_addr      out  CNT_W  beat index of the current read
//   wr_en        out  1      rd_en delayed by PIPE_LAT cycles
//   wr_addr      out  CNT_W  rd_addr delayed by PIPE_LAT cycles
//   bank_sel     out  1      ping-pong select: read bank = bank_sel, write = ~bank_sel
//   stage_start  out  1      1-cycle pulse on the first RUN cycle of each stage
//
// BEHAVIOUR
//   Reset values: all outputs 0.
//     - State = IDLE; stage, beat and drain counters = 0.
//     - Delay line cleared.
//   FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE
//     - start=1 -> RUN at the next edge; stage_idx=0, rd_addr=0, bank_sel=0.
//   RUN
//     - rd_en=1; rd_addr increments by 1 each cycle.
//     - stage_start=1 in the first cycle, when rd_addr=0.
//     - rd_addr=STAGE_CYCLES-1 -> DRAIN next cycle; rd_addr wraps to 0.
//   DRAIN
//     - rd_en=0; the drain counter counts 0..PIPE_LAT-1.
//     - At count PIPE_LAT-1:
//         if stage_idx = NUM_STAGES-1 -> DONE;
//         else stage_idx += 1, bank_sel toggles, -> RUN.
//   DONE
//     - done=1 for exactly one cycle -> IDLE.
//     - bank_sel is held, so the host knows which bank holds the result.
//   Write path
//     - Shift-register delay line of PIPE_LAT stages carrying {rd_en, rd_addr}.
//     - wr_en/wr_addr are its output. The last write of a stage lands in the
//       last DRAIN cycle, so reads and writes of different stages never overlap.
//   Latency per stage: STAGE_CYCLES + PIPE_LAT cycles.
//     - Total: NUM_STAGES*(STAGE_CYCLES+PIPE_LAT) cycles from the first RUN
//       cycle up to and including the last DRAIN cycle.
//     - done is high in the cycle after that.
//   start handling
//     - start while busy=1 is ignored. No queuing.
//     - start in the DONE cycle is ignored; the block must be in IDLE.
//   abort (priority below rst, above everything else)
//     - Next state IDLE; rd_en, stage_start and done forced 0.
//     - Delay line flushed to 0, so wr_en=0 from the next cycle.
//     - bank_sel and stage_idx reset to 0. done is not pulsed.
//   rst mid-operation: same as abort, plus every output takes its reset value.
//   Counters never exceed their ranges. stage_idx saturates at NUM_STAGES-1.
//
// TESTING  (parameters NUM_STAGES=3, STAGE_CYCLES=4, PIPE_LAT=2 unless noted)
//   1 Nominal: start pulse
//       -> rd_en high for 4 cycles with rd_addr 0,1,2,3, then low for 2 cycles.
//       -> Pattern repeats for 3 stages; stage_idx steps 0,1,2; bank_sel 0,1,0.
//       -> done pulses exactly 18 cycles after the first rd_en cycle; busy falls
//          with done.
//   2 Write path: in every stage, wr_en/wr_addr equal rd_en/rd_addr shifted by
//       exactly 2 cycles.
//       -> wr_en is never high together with rd_en of the next stage.
//   3 Start while busy: pulse start during stage 1 and in the DONE cycle
//       -> no restart; the cycle count to done is unchanged; IDLE afterwards.
//   4 Abort: assert abort at stage 1, rd_addr=2
//       -> next cycle busy=0 and rd_en=0; wr_en=0 from that cycle on.
//       -> done never pulses; a new start runs the full 18-cycle sequence.
//   5 Reset mid-DRAIN of stage 2 -> all outputs 0 next cycle; stays in IDLE
//       until start.
//   6 Defaults (11/256/8): done exactly 11*264 = 2904 cycles after the first
//       rd_en; bank_sel ends at 0.

Source files
------------

// File: rtl/ntt_stage_sequencer.sv
// Stage sequencer for the NTT datapath: walks every butterfly stage (read beats,
// then pipeline drain), drives read/write strobes, addresses and the ping-pong bank select.
module ntt_stage_sequencer #(
    parameter int NUM_STAGES   = 11,
    parameter int STAGE_CYCLES = 256,
    parameter int PIPE_LAT     = 8,
    parameter int CNT_W        = 8,
    parameter int STG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [STG_W-1:0] stage_idx,
    output logic             rd_en,
    output logic [CNT_W-1:0] rd_addr,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_addr,
    output logic             bank_sel,
    output logic             stage_start
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);
    localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DRN_W-1:0] drain_cnt;
    logic [CNT_W:0]   dly [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no latch is inferred on any path.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (rd_addr == LAST_BEAT) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == LAST_DRAIN)
                         state_nxt = (stage_idx == LAST_STAGE) ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Abort suppresses the strobes in its own cycle, not only from the next one.
    always_comb begin
        busy        = (state != IDLE);
        rd_en       = (state == RUN) && !abort;
        stage_start = rd_en && (rd_addr == '0);
        done        = (state == DONE) && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rd_addr   <= '0;
            drain_cnt <= '0;
            stage_idx <= '0;
            bank_sel  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_addr   <= '0;
                    drain_cnt <= '0;
                    if (start) begin
                        stage_idx <= '0;
                        bank_sel  <= 1'b0;
                    end
                end
                RUN: rd_addr <= (rd_addr == LAST_BEAT) ? '0 : rd_addr + 1'b1;
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        drain_cnt <= '0;
                        if (stage_idx != LAST_STAGE) begin
                            stage_idx <= stage_idx + 1'b1;
                            bank_sel  <= ~bank_sel;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;  // DONE holds stage_idx and bank_sel for the host
            endcase
        end
    end

    // NOTE: the delay line is explicitly cleared, because abort must silence wr_en on the next cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {rd_en, rd_addr};
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign {wr_en, wr_addr} = dly[PIPE_LAT-1];

endmodule
